mmio_bus: RTL and testbench
===========================

# mmio_bus

Parametrised memory-mapped bus between the CPU's memory stage and the data memory and peripherals. It decodes each CPU access to either the external data memory or a block of MMIO registers. The MMIO registers are a multiplexed 7-segment display controller with hardware scanning, a free-running system tick counter, and a reloadable timer with an interrupt. It replaces the fixed two-address decoder used with the single-cycle core and is instantiated once at the top of the pipelined CPU.

## Interface
- MMIO_BASE, 32'h40000000: MMIO window base; an address is MMIO when Addr[31:8] == MMIO_BASE[31:8].
- NUM_DIGITS, 4: display digits, legal range 1..8.
- SCAN_DIV, 50000: clk cycles per digit in scan mode, must be ≥2.

Ports:
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- Write_enable  in  1  CPU store strobe.
- Read_enable  in  1  CPU load strobe.
- WordorByte  in  1  access size, forwarded to data memory.
- Addr  in  32  byte address.
- Write_data  in  32  store data.
- Read_data  out  32  load data, combinational.
- dm_wen / dm_ren  out  1  data-memory strobes; asserted only for non-MMIO addresses.
- dm_addr / dm_wdata  out  32  pass-through of Addr / Write_data.
- dm_wordorbyte  out  1  pass-through of WordorByte.
- dm_rdata  in  32  data-memory read data.
- an  out  NUM_DIGITS  digit enables, active-low, registered.
- leds  out  7  segments a..g = bits 0..6, active-low, registered.
- irq  out  1  timer interrupt, registered.

## Operation
- Register map (offset, word-aligned; Addr[1:0] ignored):
  - 0x00 TH: timer reload value, RW.
  - 0x04 TL: timer count, RW.
  - 0x08 TCON: bit0 enable, bit1 irq enable, bit2 status. RW. Hardware sets status.
  - 0x0C DCTRL: bit0 mode (0 = raw, 1 = scan). RW.
  - 0x10 DISP: display value, RW.
  - 0x14 SYSTICK: cycle counter, read-only.
- Unmapped MMIO offsets read 0. Writes to them are ignored. They are never forwarded to data memory.
- Read_data:
  - 0 when Read_enable = 0.
  - dm_rdata for non-MMIO addresses.
  - Otherwise the selected register; unused TCON/DCTRL bits read 0.
- Timer:
  - When TCON.enable = 1, TL increments each cycle.
  - When TL == 32'hFFFFFFFF, the next cycle loads TL <= TH and sets TCON.status.
  - irq = status & irq enable.
- SYSTICK increments every cycle and wraps at 2^32.
- Raw mode: a DISP write sets an <= Write_data[NUM_DIGITS+7:8] and leds <= Write_data[6:0].
- Scan mode:
  - Digit index k cycles 0..NUM_DIGITS-1 and advances every SCAN_DIV cycles.
  - an has only bit k low.
  - leds = hex-to-7-segment decode of DISP[4k+3:4k], covering 0–F.
- Simultaneous events:
  - A CPU write to TL in the overflow cycle wins over the reload.
  - A TCON write clearing status in the overflow cycle: the set wins.
  - A write to SYSTICK is ignored.
  - A DCTRL mode change resets k and the scan counter to 0.

## Timing
- Register writes take effect at the clk edge that samples Write_enable.
- Reads are same-cycle combinational.
- irq asserts one cycle after status sets.
- In scan mode, an/leds update one cycle after a DISP write or digit advance.
- Reset (any cycle, including mid-scan or mid-count) sets:
  - TH, TL, TCON, DCTRL, DISP and SYSTICK to 0.
  - k and the scan counter to 0.
  - an to all ones, leds to 7'h7F, irq to 0.
- Data-memory strobes are combinational from the inputs; no added latency.

## Configuration
- PERIPH_TIMER_EN defined: TH, TL, TCON and irq behave as specified.
- PERIPH_TIMER_EN undefined: no timer logic is built. Offsets 0x00–0x08 read 0 and ignore writes. irq is tied to 0.
- SYSTICK and the display are unaffected by the macro.

## Structure
- Shared package mmio_pkg holds:
  - register offset constants (OFF_TH, OFF_TL, OFF_TCON, OFF_DCTRL, OFF_DISP, OFF_SYSTICK);
  - TCON bit indices;
  - the 16-entry hex-to-segment constant table.
- One sub-module, seg7_scanner, holds the scan counter, digit index, nibble select and decode.
  - Parameters: NUM_DIGITS, SCAN_DIV.
  - Inputs: clk, reset, mode, value.
  - Outputs: registered an and leds.
- The raw-mode registers stay in mmio_bus and are muxed with the seg7_scanner outputs.

## Test plan
- Decode: store 0x1234 to 0x00000010, then load it → dm_wen pulses, Read_data = dm_rdata. Store to 0x40000010 → dm_wen stays 0.
- Raw display: DCTRL = 0, store 0x00000E3F to DISP → next cycle an = 4'hE, leds = 7'h3F. Read DISP = 0x00000E3F.
- Scan: SCAN_DIV = 4, DCTRL = 1, DISP = 0x00004321 → an steps E, D, B, 7 every 4 cycles, with leds = decode(1, 2, 3, 4), then wraps to E.
- Timer: TH = 0xFFFFFFFD, TL = 0xFFFFFFFD, TCON = 3 → TL reaches 0xFFFFFFFF after 2 cycles, reloads to 0xFFFFFFFD, status sets, irq = 1 one cycle later. Writing TCON = 3 clears irq.
- Overflow collision: write TCON = 3 in the exact overflow cycle → status remains 1. Write TL = 5 in the overflow cycle → TL = 5.
- Reset mid-operation: assert reset during scan and timer count → all registers 0, an all ones, leds 7'h7F, irq 0 on the next edge. Read SYSTICK = 0 in the cycle right after reset.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped peripheral bus.
//   - Register offsets inside the MMIO window (byte offsets, word aligned).
//   - TCON bit positions.
//   - Hex-to-7-segment table, active-low, segments a..g on bits 0..6.
package mmio_pkg;

    localparam logic [7:0] OFF_TH      = 8'h00;
    localparam logic [7:0] OFF_TL      = 8'h04;
    localparam logic [7:0] OFF_TCON    = 8'h08;
    localparam logic [7:0] OFF_DCTRL   = 8'h0C;
    localparam logic [7:0] OFF_DISP    = 8'h10;
    localparam logic [7:0] OFF_SYSTICK = 8'h14;

    localparam int TCON_EN = 0;   // timer count enable
    localparam int TCON_IE = 1;   // interrupt enable
    localparam int TCON_ST = 2;   // overflow status, set by hardware

    // Active-low segment patterns for 0..F (bit0 = a ... bit6 = g).
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/mmio_bus_if.sv
// mmio_bus_if: CPU memory-stage access bus.
//   Write_enable / Read_enable : store / load strobes
//   WordorByte                 : access size
//   Addr, Write_data           : byte address and store data
//   Read_data                  : load data returned by the bus (combinational)
// master = CPU side, slave = mmio_bus side.
interface mmio_bus_if;
    logic        Write_enable;
    logic        Read_enable;
    logic        WordorByte;
    logic [31:0] Addr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (
        output Write_enable, Read_enable, WordorByte, Addr, Write_data,
        input  Read_data
    );

    modport slave (
        input  Write_enable, Read_enable, WordorByte, Addr, Write_data,
        output Read_data
    );
endinterface

// File: rtl/seg7_scanner.sv
// seg7_scanner: multiplexed 7-segment scan engine.
//   clk, reset : clock and synchronous active-high reset
//   mode       : 1 = scanning, 0 = idle (digit index and scan counter held at 0)
//   value      : one hex nibble per digit, digit k on bits [4k+3:4k]
//   an         : registered active-low digit enables, only the current digit low
//   leds       : registered active-low segments of the current digit
// Outputs lag the digit index by one cycle, so a digit advance or a new value
// shows up on an/leds one cycle later.
module seg7_scanner
    import mmio_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              leds
);

    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            leds_q, leds_d;
    logic [3:0]            nibble;

    always_comb begin
        cnt_d = cnt_q;
        k_d   = k_q;
        // Holding the counters at zero outside scan mode means any mode
        // change starts the scan from digit 0 with a fresh period.
        if (!mode) begin
            cnt_d = '0;
            k_d   = '0;
        end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            k_d   = (k_q == KW'(NUM_DIGITS - 1)) ? '0 : k_q + KW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        nibble = value[4*int'(k_q) +: 4];
        an_d   = ~(NUM_DIGITS'(1) << k_q);
        leds_d = SEG_LUT[nibble];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            k_q    <= '0;
            an_q   <= '1;
            leds_q <= 7'h7F;
        end else begin
            cnt_q  <= cnt_d;
            k_q    <= k_d;
            an_q   <= an_d;
            leds_q <= leds_d;
        end
    end

    assign an   = an_q;
    assign leds = leds_q;

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: address decoder between the CPU memory stage, data memory and
// the MMIO register block (timer, system tick, 7-segment display).
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : CPU access bus, Read_data is combinational
//   dm_wen / dm_ren   : data-memory strobes, only for non-MMIO addresses
//   dm_addr, dm_wdata, dm_wordorbyte : pass-through to data memory
//   dm_rdata          : data-memory read data
//   an, leds          : active-low digit enables / segments
//   irq               : timer interrupt
// Build option: define PERIPH_TIMER_EN to build TH/TL/TCON and irq; without it
// offsets 0x00-0x08 read 0, writes there are dropped, and irq is 0.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE  = 32'h4000_0000,
    parameter int          NUM_DIGITS = 4,
    parameter int          SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_bus_if.slave             bus,
    output logic                  dm_wen,
    output logic                  dm_ren,
    output logic [31:0]           dm_addr,
    output logic [31:0]           dm_wdata,
    output logic                  dm_wordorbyte,
    input  logic [31:0]           dm_rdata,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            leds,
    output logic                  irq
);

    logic       is_mmio;
    logic       wr_mmio;
    logic [5:0] off;

    assign is_mmio = (bus.Addr[31:8] == MMIO_BASE[31:8]);
    assign off     = bus.Addr[7:2];
    assign wr_mmio = bus.Write_enable & is_mmio;

    assign dm_wen        = bus.Write_enable & ~is_mmio;
    assign dm_ren        = bus.Read_enable  & ~is_mmio;
    assign dm_addr       = bus.Addr;
    assign dm_wdata      = bus.Write_data;
    assign dm_wordorbyte = bus.WordorByte;

    // System tick and display registers
    logic [31:0]           systick_q, systick_d;
    logic                  dctrl_q, dctrl_d;
    logic [31:0]           disp_q, disp_d;
    logic [NUM_DIGITS-1:0] an_raw_q, an_raw_d;
    logic [6:0]            leds_raw_q, leds_raw_d;

    always_comb begin
        systick_d  = systick_q + 32'd1;
        dctrl_d    = dctrl_q;
        disp_d     = disp_q;
        an_raw_d   = an_raw_q;
        leds_raw_d = leds_raw_q;
        if (wr_mmio) begin
            if (off == OFF_DCTRL[7:2]) dctrl_d = bus.Write_data[0];
            if (off == OFF_DISP[7:2]) begin
                disp_d = bus.Write_data;
                // Raw mode drives the pins straight from the stored word.
                if (!dctrl_q) begin
                    an_raw_d   = bus.Write_data[NUM_DIGITS+7:8];
                    leds_raw_d = bus.Write_data[6:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q  <= '0;
            dctrl_q    <= 1'b0;
            disp_q     <= '0;
            an_raw_q   <= '1;
            leds_raw_q <= 7'h7F;
        end else begin
            systick_q  <= systick_d;
            dctrl_q    <= dctrl_d;
            disp_q     <= disp_d;
            an_raw_q   <= an_raw_d;
            leds_raw_q <= leds_raw_d;
        end
    end

    logic [NUM_DIGITS-1:0] scan_an;
    logic [6:0]            scan_leds;

    seg7_scanner #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scanner (
        .clk   (clk),
        .reset (reset),
        .mode  (dctrl_q),
        .value (disp_q[4*NUM_DIGITS-1:0]),
        .an    (scan_an),
        .leds  (scan_leds)
    );

    assign an   = dctrl_q ? scan_an   : an_raw_q;
    assign leds = dctrl_q ? scan_leds : leds_raw_q;

`ifdef PERIPH_TIMER_EN
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        irq_q, irq_d;
    logic        ovf;

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        ovf    = 1'b0;
        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                ovf  = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        // CPU writes override the count/reload, but a coincident overflow
        // still sets status even if the written TCON clears it.
        if (wr_mmio) begin
            if (off == OFF_TH[7:2])   th_d   = bus.Write_data;
            if (off == OFF_TL[7:2])   tl_d   = bus.Write_data;
            if (off == OFF_TCON[7:2]) tcon_d = bus.Write_data[2:0];
        end
        if (ovf) tcon_d[TCON_ST] = 1'b1;
        irq_d = tcon_q[TCON_ST] & tcon_q[TCON_IE];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        bus.Read_data = '0;
        if (bus.Read_enable) begin
            if (!is_mmio) begin
                bus.Read_data = dm_rdata;
            end else begin
                case (off)
`ifdef PERIPH_TIMER_EN
                    OFF_TH[7:2]:      bus.Read_data = th_q;
                    OFF_TL[7:2]:      bus.Read_data = tl_q;
                    OFF_TCON[7:2]:    bus.Read_data = {29'd0, tcon_q};
`endif
                    OFF_DCTRL[7:2]:   bus.Read_data = {31'd0, dctrl_q};
                    OFF_DISP[7:2]:    bus.Read_data = disp_q;
                    OFF_SYSTICK[7:2]: bus.Read_data = systick_q;
                    default:          bus.Read_data = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: self-checking bench for mmio_bus (4 digits, SCAN_DIV = 4).
module tb_mmio_bus;

    localparam int          ND   = 4;
    localparam int          SD   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE + 32'h00;
    localparam logic [31:0] A_TL = BASE + 32'h04;
    localparam logic [31:0] A_TC = BASE + 32'h08;
    localparam logic [31:0] A_DC = BASE + 32'h0C;
    localparam logic [31:0] A_DS = BASE + 32'h10;
    localparam logic [31:0] A_ST = BASE + 32'h14;

    logic          clk = 1'b0;
    logic          reset;
    logic          dm_wen, dm_ren, dm_wordorbyte;
    logic [31:0]   dm_addr, dm_wdata, dm_rdata;
    logic [ND-1:0] an;
    logic [6:0]    leds;
    logic          irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [10:0] scan_q[$];

    // Active-high gfedcba patterns; the DUT drives the inverse.
    logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    mmio_bus_if bus();

    mmio_bus #(.MMIO_BASE(BASE), .NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .dm_wen        (dm_wen),
        .dm_ren        (dm_ren),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_wordorbyte (dm_wordorbyte),
        .dm_rdata      (dm_rdata),
        .an            (an),
        .leds          (leds),
        .irq           (irq)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr         = a;
        bus.Write_data   = d;
        bus.Write_enable = 1'b1;
        tick();
        bus.Write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.Addr        = a;
        bus.Read_enable = 1'b1;
        #1;
        d = bus.Read_data;
        bus.Read_enable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        rd(A_ST, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_systick: got %h want %h", v, 32'd0); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want %h", an, 4'hF); end
        checks++; if (leds !== 7'h7F) begin errors++; $display("FAIL reset_leds: got %h want %h", leds, 7'h7F); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        rd(A_DS, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_disp: got %h want 0", v); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        bus.Addr = 32'h10; bus.Write_data = 32'h1234; bus.WordorByte = 1'b1; bus.Write_enable = 1'b1;
        #1;
        checks++; if (dm_wen !== 1'b1) begin errors++; $display("FAIL dm_wen_mem: got %b want 1", dm_wen); end
        checks++; if (dm_addr !== 32'h10 || dm_wdata !== 32'h1234 || dm_wordorbyte !== 1'b1) begin
            errors++; $display("FAIL dm_pass: got %h/%h/%b want 00000010/00001234/1", dm_addr, dm_wdata, dm_wordorbyte); end
        tick();
        bus.Write_enable = 1'b0;
        dm_rdata = 32'hCAFE_0001;
        exp_q.push_back(32'hCAFE_0001);
        bus.Addr = 32'h10; bus.Read_enable = 1'b1;
        #1;
        checks++; if (dm_ren !== 1'b1) begin errors++; $display("FAIL dm_ren_mem: got %b want 1", dm_ren); end
        v = exp_q.pop_front();
        checks++; if (bus.Read_data !== v) begin errors++; $display("FAIL load_mem: got %h want %h", bus.Read_data, v); end
        bus.Read_enable = 1'b0;
        #1;
        checks++; if (bus.Read_data !== 32'd0) begin errors++; $display("FAIL read_idle: got %h want 0", bus.Read_data); end
        bus.Addr = A_DS; bus.Write_data = 32'h0; bus.Write_enable = 1'b1;
        #1;
        checks++; if (dm_wen !== 1'b0) begin errors++; $display("FAIL dm_wen_mmio: got %b want 0", dm_wen); end
        tick();
        bus.Write_enable = 1'b0;
        wr(BASE + 32'h20, 32'hFFFF_FFFF);
        bus.Addr = BASE + 32'h20; bus.Read_enable = 1'b1;
        #1;
        checks++; if (bus.Read_data !== 32'd0 || dm_ren !== 1'b0) begin
            errors++; $display("FAIL unmapped: got %h ren=%b want 0 ren=0", bus.Read_data, dm_ren); end
        bus.Read_enable = 1'b0;
        wr(A_ST, 32'h8000_0000);
        rd(A_ST, v);
        checks++; if ((v < 32'd1000) !== 1'b1) begin errors++; $display("FAIL systick_ro: got %h want small count", v); end
    endtask

    task automatic test_raw_display();
        logic [31:0] v;
        wr(A_DC, 32'd0);
        wr(A_DS, 32'h0000_0E3F);
        checks++; if (an !== 4'hE) begin errors++; $display("FAIL raw_an: got %h want e", an); end
        checks++; if (leds !== 7'h3F) begin errors++; $display("FAIL raw_leds: got %h want 3f", leds); end
        rd(A_DS, v);
        checks++; if (v !== 32'h0000_0E3F) begin errors++; $display("FAIL raw_disp_rd: got %h want 00000e3f", v); end
    endtask

    task automatic test_scan();
        logic [31:0] v;
        logic [10:0] e;
        int d;
        wr(A_DS, 32'h0000_4321);
        wr(A_DC, 32'd1);
        rd(A_DC, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL dctrl_rd: got %h want 1", v); end
        for (int n = 0; n < 21; n++) begin
            d = (n == 0) ? 0 : ((n - 1) / SD) % ND;
            e[10:7] = ~(4'b0001 << d);
            e[6:0]  = ~seg_hi[(32'h4321 >> (4 * d)) & 32'hF];
            scan_q.push_back(e);
            e = scan_q.pop_front();
            checks++; if ({an, leds} !== e) begin
                errors++; $display("FAIL scan_step%0d: got an=%h leds=%h want an=%h leds=%h", n, an, leds, e[10:7], e[6:0]); end
            tick();
        end
    endtask

`ifdef PERIPH_TIMER_EN
    task automatic test_timer();
        logic [31:0] v;
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TC, 32'd3);
        rd(A_TL, v);
        checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL tl_start: got %h want fffffffd", v); end
        tick();
        rd(A_TL, v);
        checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tl_inc: got %h want fffffffe", v); end
        tick();
        rd(A_TL, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tl_max: got %h want ffffffff", v); end
        tick();
        rd(A_TL, v);
        checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL tl_reload: got %h want fffffffd", v); end
        rd(A_TC, v);
        checks++; if (v !== 32'd7) begin errors++; $display("FAIL tcon_status: got %h want 7", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
        wr(A_TL, 32'd0);
        wr(A_TC, 32'd3);
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        rd(A_TC, v);
        checks++; if (v !== 32'd3) begin errors++; $display("FAIL tcon_clear: got %h want 3", v); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        wr(A_TC, 32'd0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'd3);
        tick();
        rd(A_TL, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL col_tl_max: got %h want ffffffff", v); end
        wr(A_TC, 32'd3);
        rd(A_TC, v);
        checks++; if (v !== 32'd7) begin errors++; $display("FAIL col_status: got %h want 7", v); end
        rd(A_TL, v);
        checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL col_reload: got %h want fffffffd", v); end
        tick();
        tick();
        wr(A_TL, 32'd5);
        rd(A_TL, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL col_tl_write: got %h want 5", v); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL col_irq: got %b want 1", irq); end
    endtask
`else
    task automatic test_timer_absent();
        logic [31:0] v;
        wr(A_TH, 32'h1234_5678);
        wr(A_TL, 32'h9ABC_DEF0);
        wr(A_TC, 32'd7);
        tick();
        rd(A_TH, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL notimer_th: got %h want 0", v); end
        rd(A_TL, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL notimer_tl: got %h want 0", v); end
        rd(A_TC, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL notimer_tcon: got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL notimer_irq: got %b want 0", irq); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(A_DS, 32'h0000_5A5A);
        wr(A_TH, 32'h0000_0010);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'd3);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (an !== 4'hF || leds !== 7'h7F) begin
            errors++; $display("FAIL mid_pins: got an=%h leds=%h want f/7f", an, leds); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b want 0", irq); end
        rd(A_ST, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_systick: got %h want 0", v); end
        rd(A_TH, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_th: got %h want 0", v); end
        rd(A_TL, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_tl: got %h want 0", v); end
        rd(A_TC, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_tcon: got %h want 0", v); end
        rd(A_DC, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_dctrl: got %h want 0", v); end
        rd(A_DS, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_disp: got %h want 0", v); end
        tick();
        rd(A_ST, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL mid_systick_run: got %h want 1", v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        dm_rdata         = 32'd0;
        bus.Write_enable = 1'b0;
        bus.Read_enable  = 1'b0;
        bus.WordorByte   = 1'b0;
        bus.Addr         = 32'd0;
        bus.Write_data   = 32'd0;
        test_reset();
        test_decode();
        test_raw_display();
        test_scan();
`ifdef PERIPH_TIMER_EN
        test_timer();
        test_collision();
`else
        test_timer_absent();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
